// File: rtl/serial_adder_seq.sv
// ============================================================================
// Module   : serial_adder_seq
// Brief    : Bit-serial LSB-first adder, one full-adder cell plus carry flop.
//            Optional signed-overflow output when SERIAL_ADDER_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              c_CW    = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);
    localparam logic [1:0]      c_IDLE  = 2'd0;
    localparam logic [1:0]      c_SHIFT = 2'd1;
    localparam logic [1:0]      c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_c;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-2:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    assign w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_c;
    assign w_c        = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c) | (r_b_sr[0] & r_c);
    assign w_last     = (r_cnt == c_LAST);
    // The shift register keeps only the upper WIDTH-1 bits; the final bit
    // lands directly in the output register on the last shift edge.
    assign w_sum_next = {w_s, r_sum_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state  <= c_SHIFT;
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_c      <= cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_sum    <= '0;
                        r_cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf    <= 1'b0;
`endif
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_SHIFT: begin
                    r_c      <= w_c;
                    r_sum_sr <= w_sum_next[WIDTH-1:1];
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_sum   <= w_sum_next;
                        r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_c here is the carry into the MSB, w_c the carry out
                        r_ovf   <= r_c ^ w_c;
`endif
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_SHIFT);
    assign done = (r_state == c_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
// ============================================================================
// Module   : tb_serial_adder_seq
// Brief    : Scoreboard bench for serial_adder_seq (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_bit;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    // expected word: {ovf, cout, sum}
    logic [W+1:0] sb_q[$];

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf;
    assign ovf_bit = ovf;
`else
    assign ovf_bit = 1'b0;
`endif

    serial_adder_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [W+1:0] pack_exp(input logic o, input logic c, input logic [W-1:0] s);
`ifdef SERIAL_ADDER_OVF_EN
        return {o, c, s};
`else
        return {1'b0, c, s};
`endif
    endfunction

    // Reference: integer add plus sign-rule overflow (same signs in, different sign out)
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        logic [W:0] r;
        logic       o;
        r = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        o = (ta[W-1] == tb[W-1]) && (r[W-1] != ta[W-1]);
        return pack_exp(o, r[W], r[W-1:0]);
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            chk("busy_with_done", {31'b0, busy}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("result", {{(30-W){1'b0}}, ovf_bit, cout, sum}, {{(30-W){1'b0}}, sb_q.pop_front()});
            end
        end
    end

    // Issue one op from a point #1 after a rising edge; returns #1 after the
    // edge that enters DONE, so a following call starts back-to-back.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W+1:0] exp);
        int n;
        a = ta; b = tb; cin = tc; start = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("sum_cleared", {{(31-W){1'b0}}, cout, sum}, 32'd0);
        n = 0;
        while (!done && n < W + 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    initial begin
        int d0;
        // reset state
        idle_cycles(2);
        chk("reset_state", {28'b0, busy, done, cout, ovf_bit}, 32'd0);
        chk("reset_sum", {{(32-W){1'b0}}, sum}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // directed, hand-computed
        issue(4'b0001, 4'b0010, 1'b0, pack_exp(1'b0, 1'b0, 4'b0011));
        idle_cycles(1);
        chk("hold_in_idle", {{(31-W){1'b0}}, cout, sum}, 32'h03);
        issue(4'b0101, 4'b0011, 1'b1, pack_exp(1'b1, 1'b0, 4'b1001));
        idle_cycles(2);
        issue(4'b1111, 4'b1111, 1'b1, pack_exp(1'b0, 1'b1, 4'b1111));
        issue(4'b1010, 4'b0101, 1'b0, pack_exp(1'b0, 1'b0, 4'b1111));   // back-to-back
        idle_cycles(2);

        // start pulsed mid-SHIFT with other operands must be ignored
        d0 = n_done;
        a = 4'b0110; b = 4'b0111; cin = 1'b0; start = 1'b1;
        sb_q.push_back(pack_exp(1'b1, 1'b0, 4'b1101));
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(1);
        a = 4'b1111; b = 4'b1111; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(W + 4);
        chk("single_done", n_done - d0, 1);

        // reset while idle with a held nonzero result
        issue(4'b0111, 4'b0001, 1'b0, pack_exp(1'b1, 1'b0, 4'b1000));
        idle_cycles(1);
        #2 rst = 1'b1;
        #1 chk("rst_idle_clears", {{(29-W){1'b0}}, busy, done, cout, sum}, 32'd0);
        #3 rst = 1'b0;
        idle_cycles(1);

        // reset mid-SHIFT aborts at once; no done may follow
        d0 = n_done;
        a = 4'b0101; b = 4'b0011; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1 chk("rst_shift_clears", {{(29-W){1'b0}}, busy, done, cout, sum}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_bit}, 32'd0);
        #3 rst = 1'b0;
        idle_cycles(W + 3);
        chk("idle_after_rst", {30'b0, busy, done}, 32'd0);
        chk("no_done_after_rst", n_done - d0, 0);

        // first op after reset, then exhaustive sweep against the model
        issue(4'b0011, 4'b0011, 1'b0, pack_exp(1'b0, 1'b0, 4'b0110));
        for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
            logic [2*W:0] v;
            v = (2 * W + 1)'(i);
            issue(v[W-1:0], v[2*W-1:W], v[2*W], model(v[W-1:0], v[2*W-1:W], v[2*W]));
        end
        idle_cycles(3);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
